// File: rtl/lsu_avalon.sv
// Load/store unit bridging a single-issue core to an Avalon-MM master port.
// One transaction in flight; byte/half/word accesses with lane steering and load extension.
module lsu_avalon (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        done,
  output logic        err,
  output logic        rf_write,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, RD_WAIT, RESP} state_t;

  state_t      state, state_d;
  logic [1:0]  addr_lo, addr_lo_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [4:0]  rd_q, rd_d;

  logic        done_d, err_d, rf_write_d, avm_read_d, avm_write_d;
  logic [4:0]  rf_wa_d;
  logic [31:0] rf_wd_d, avm_address_d, avm_writedata_d;
  logic [3:0]  avm_byteenable_d;

  logic        misaligned;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

  assign misaligned = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // Lane selection uses the latched low address bits, not the live request.
  assign lane_b = avm_readdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = avm_readdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'b00:   load_val = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_val = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = avm_readdata;
    endcase
  end

  // NOTE: every next-value signal gets a default before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d          = state;
    addr_lo_d        = addr_lo;
    size_d           = size_q;
    uns_d            = uns_q;
    rd_d             = rd_q;
    done_d           = 1'b0;
    err_d            = 1'b0;
    rf_write_d       = 1'b0;
    rf_wa_d          = rf_wa;
    rf_wd_d          = rf_wd;
    avm_read_d       = avm_read;
    avm_write_d      = avm_write;
    avm_address_d    = avm_address;
    avm_writedata_d  = avm_writedata;
    avm_byteenable_d = avm_byteenable;

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            addr_lo_d     = req_addr[1:0];
            size_d        = req_size;
            uns_d         = req_unsigned;
            rd_d          = req_rd;
            avm_address_d = {req_addr[31:2], 2'b00};
            case (req_size)
              2'b00: begin
                avm_byteenable_d = 4'b0001 << req_addr[1:0];
                avm_writedata_d  = {4{req_wdata[7:0]}};
              end
              2'b01: begin
                avm_byteenable_d = 4'b0011 << req_addr[1:0];
                avm_writedata_d  = {2{req_wdata[15:0]}};
              end
              default: begin
                avm_byteenable_d = 4'b1111;
                avm_writedata_d  = req_wdata;
              end
            endcase
            if (req_we) begin
              avm_write_d = 1'b1;
              state_d     = WR_REQ;
            end else begin
              avm_read_d = 1'b1;
              state_d    = RD_REQ;
            end
          end
        end
      end
      WR_REQ: begin
        if (!avm_waitrequest) begin
          avm_write_d = 1'b0;
          done_d      = 1'b1;
          state_d     = RESP;
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest) begin
          avm_read_d = 1'b0;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          rf_wd_d    = load_val;
          rf_wa_d    = rd_q;
          rf_write_d = (rd_q != 5'd0);
          done_d     = 1'b1;
          state_d    = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr_lo        <= 2'b00;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      rd_q           <= 5'd0;
      done           <= 1'b0;
      err            <= 1'b0;
      rf_write       <= 1'b0;
      rf_wa          <= 5'd0;
      rf_wd          <= 32'd0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= 32'd0;
      avm_writedata  <= 32'd0;
      avm_byteenable <= 4'b0000;
    end else begin
      state          <= state_d;
      addr_lo        <= addr_lo_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      rd_q           <= rd_d;
      done           <= done_d;
      err            <= err_d;
      rf_write       <= rf_write_d;
      rf_wa          <= rf_wa_d;
      rf_wd          <= rf_wd_d;
      avm_read       <= avm_read_d;
      avm_write      <= avm_write_d;
      avm_address    <= avm_address_d;
      avm_writedata  <= avm_writedata_d;
      avm_byteenable <= avm_byteenable_d;
    end
  end

endmodule

// File: tb/tb_lsu_avalon.sv
// Self-checking bench for lsu_avalon: transaction-level model, per-cycle monitor,
// randomized Avalon slave with wait states, stray readdatavalid and reset abort.
module tb_lsu_avalon;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        done, err, rf_write;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [3:0]  avm_byteenable;

  lsu_avalon dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .done(done), .err(err), .rf_write(rf_write), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expectations for the transaction currently in flight
  logic        exp_active = 1'b0;
  logic        exp_load, exp_err, exp_rf_write;
  logic [31:0] exp_addr, exp_wd, exp_rf_wd;
  logic [3:0]  exp_be;
  logic [4:0]  exp_rd;

  // Monitor-owned event counters and captures
  int          done_cnt = 0, err_cnt = 0, rf_cnt = 0, strobe_cnt = 0;
  int          done_cyc = 0, err_cyc = 0;
  logic [31:0] last_addr = 0, last_wd = 0, last_rf_wd = 0;
  logic [3:0]  last_be = 0;
  logic [4:0]  last_rf_wa = 0;

  always @(negedge clk) begin
    check("strobe_exclusive", {31'b0, avm_read & avm_write}, 0);
    if (avm_read || avm_write) begin
      strobe_cnt++;
      last_addr = avm_address;
      last_be   = avm_byteenable;
      last_wd   = avm_writedata;
      check("strobe_expected", {31'b0, exp_active && !exp_err}, 1);
      check("strobe_kind", {30'b0, avm_read, avm_write}, exp_load ? 2 : 1);
      check("avm_address", avm_address, exp_addr);
      check("avm_byteenable", {28'b0, avm_byteenable}, {28'b0, exp_be});
      if (avm_write) check("avm_writedata", avm_writedata, exp_wd);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_expected", {31'b0, exp_active && !exp_err}, 1);
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
      check("err_expected", {31'b0, exp_active && exp_err}, 1);
    end
    if (rf_write) begin
      rf_cnt++;
      last_rf_wa = rf_wa;
      last_rf_wd = rf_wd;
      check("rf_write_expected", {31'b0, exp_active && exp_rf_write}, 1);
      check("rf_write_with_done", {31'b0, done}, 1);
      check("rf_wa", {27'b0, rf_wa}, {27'b0, exp_rd});
      check("rf_wd", rf_wd, exp_rf_wd);
    end
  end

  // Reference: load result from the addressed lane, extended by plain arithmetic
  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v;
    if (size == 2'b00) begin
      v = (rdata >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'b01) begin
      v = (rdata >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                     input int waits, input int dvdelay, input logic [31:0] rdata);
    int  t0, d0, e0, r0, s0, waitcnt, dv_cnt, lat;
    logic finished, in_wait;
    exp_load     = !we;
    exp_err      = (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) ||
                   (size == 2'b10 && addr % 4 != 0);
    exp_addr     = addr - (addr % 4);
    exp_be       = (size == 2'b00) ? 4'd1 << (addr % 4) :
                   (size == 2'b01) ? 4'd3 << (addr % 4) : 4'hF;
    exp_wd       = (size == 2'b00) ? (wdata & 32'hFF) * 32'h0101_0101 :
                   (size == 2'b01) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
    exp_rd       = rd;
    exp_rf_wd    = ref_load(size, uns, addr, rdata);
    exp_rf_write = !we && !exp_err && rd != 0;
    lat          = exp_err ? 1 : (we ? waits + 2 : waits + dvdelay + 3);

    @(posedge clk); #1;
    d0 = done_cnt; e0 = err_cnt; r0 = rf_cnt; s0 = strobe_cnt;
    exp_active   = 1'b1;
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
    avm_waitrequest   = 1'($urandom % 2);
    avm_readdatavalid = 1'($urandom % 2);
    avm_readdata      = $urandom;
    t0 = cyc; waitcnt = 0; dv_cnt = -1; finished = 1'b0; in_wait = 1'b0;

    for (int i = 0; i < 60 && !finished; i++) begin
      @(posedge clk); #1;
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (done || err) begin
        req_valid = 1'b0;
        finished  = 1'b1;
      end
      if (dv_cnt == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rdata;
        dv_cnt            = -1;
        in_wait           = 1'b0;
      end else if (dv_cnt > 0) begin
        dv_cnt--;
      end else if (!in_wait) begin
        avm_readdatavalid = 1'($urandom % 2);
      end
      if (avm_read || avm_write) begin
        if (waitcnt < waits) begin
          avm_waitrequest = 1'b1;
          waitcnt++;
        end else begin
          avm_waitrequest = 1'b0;
          if (avm_read) begin
            in_wait = 1'b1;
            dv_cnt  = dvdelay;
          end
        end
      end else begin
        avm_waitrequest = 1'($urandom % 2);
      end
    end
    req_valid = 1'b0;
    check("txn_completed", {31'b0, finished}, 1);

    repeat (2) begin
      @(posedge clk); #1;
      avm_readdatavalid = 1'($urandom % 2);
      avm_readdata      = $urandom;
    end
    avm_readdatavalid = 1'b0;

    check("done_count", done_cnt - d0, exp_err ? 0 : 1);
    check("err_count", err_cnt - e0, exp_err ? 1 : 0);
    check("rf_write_count", rf_cnt - r0, exp_rf_write ? 1 : 0);
    check("strobe_cycles", strobe_cnt - s0, exp_err ? 0 : waits + 1);
    if (finished) check("latency", (exp_err ? err_cyc : done_cyc) - t0, lat);
    exp_active = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"}, {31'b0, done}, 0);
    check({tag, "_err"}, {31'b0, err}, 0);
    check({tag, "_rf_write"}, {31'b0, rf_write}, 0);
    check({tag, "_avm_read"}, {31'b0, avm_read}, 0);
    check({tag, "_avm_write"}, {31'b0, avm_write}, 0);
    check({tag, "_avm_address"}, avm_address, 0);
    check({tag, "_avm_writedata"}, avm_writedata, 0);
    check({tag, "_avm_byteenable"}, {28'b0, avm_byteenable}, 0);
    check({tag, "_rf_wa"}, {27'b0, rf_wa}, 0);
    check({tag, "_rf_wd"}, rf_wd, 0);
  endtask

  initial begin
    int r0, d0;
    logic [31:0] a;
    logic [1:0]  sz;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 0; req_wdata = 0; req_rd = 0;
    avm_waitrequest = 1'b0; avm_readdata = 0; avm_readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // LB sign-extended from the top lane
    txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 5'd7, 0, 0, 32'h80FF_FFFF);
    check("lb_rf_wd", last_rf_wd, 32'hFFFF_FF80);
    check("lb_address", last_addr, 32'h0000_1000);
    check("lb_byteenable", {28'b0, last_be}, 32'h8);

    // LHU from the upper half
    txn(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 5'd5, 0, 1, 32'hBEEF_1234);
    check("lhu_rf_wa", {27'b0, last_rf_wa}, 5);
    check("lhu_rf_wd", last_rf_wd, 32'h0000_BEEF);

    // SH with three wait states
    txn(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_ABCD, 5'd0, 3, 0, 32'h0);
    check("sh_writedata", last_wd, 32'hABCD_ABCD);
    check("sh_byteenable", {28'b0, last_be}, 32'hC);

    // Misaligned word load and reserved-size store
    txn(1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0, 5'd9, 0, 0, 32'h1234_5678);
    txn(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h5555_AAAA, 5'd0, 0, 0, 32'h0);

    // LW to x0: done but no register write
    txn(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 5'd0, 1, 2, 32'hCAFE_F00D);

    // Randomized mix
    for (int n = 0; n < 80; n++) begin
      a  = $urandom;
      sz = 2'($urandom % 4);
      if ($urandom % 3 != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      txn(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom, 5'($urandom % 32),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset while waiting for read data; a late readdatavalid must be dropped
    r0 = rf_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    exp_active = 1'b1; exp_load = 1'b1; exp_err = 1'b0; exp_rf_write = 1'b1;
    exp_addr = 32'h0000_0100; exp_be = 4'hF; exp_rd = 5'd3; exp_rf_wd = 32'h0;
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_0100; req_rd = 5'd3; req_valid = 1'b1;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    @(posedge clk); #1;
    check("abort_read_strobe", {31'b0, avm_read}, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_active = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("abort_reset");
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("abort_after");
    check("abort_rf_write_count", rf_cnt - r0, 0);
    check("abort_done_count", done_cnt - d0, 0);

    // Unit still works after the abort
    txn(1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 5'd12, 0, 0, 32'h00C3_A500);
    check("post_abort_rf_wd", last_rf_wd, 32'h0000_00A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
